// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic, S-boxes, round transforms and key-schedule steps.
// AES_DEC_KEY_EXPAND_EN adds the KEYEXP state and the forward key-schedule step.
package aes_pkg;

  localparam int NR = 10;

`ifdef AES_DEC_KEY_EXPAND_EN
  typedef enum logic [1:0] {IDLE, ROUND, KEYEXP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ROUND} state_t;
`endif

  function automatic logic [7:0] gm2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = gm2(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, t;
    r = 8'h01;
    t = a;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = ginv(x);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3;
    {w0, w1, w2, w3} = k;
    n3 = w3 ^ w2;
    n2 = w2 ^ w1;
    n1 = w1 ^ w0;
    n0 = w0 ^ sub_word({n3[23:0], n3[31:24]}) ^ {rc, 24'h0};
    return {n0, n1, n2, n3};
  endfunction

`ifdef AES_DEC_KEY_EXPAND_EN
  function automatic logic [127:0] fwd_key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3;
    {w0, w1, w2, w3} = k;
    n0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction
`endif

  // Byte b of the state lives at [127-8b -: 8]; b = row + 4*column.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int b = 0; b < 16; b++) o[127-8*b -: 8] = inv_sbox(s[127-8*b -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_dec_key_sched.sv
// Round-key register for the inverse cipher, stepped backwards one round per cycle.
// AES_DEC_KEY_EXPAND_EN: load takes the cipher key and a forward step is added.
module aes_dec_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
`ifdef AES_DEC_KEY_EXPAND_EN
  input  logic         fwd_step,
`endif
  input  logic [3:0]   rnd,
  input  logic [127:0] key_in,
  output logic [127:0] key
);

  always_ff @(posedge clk) begin
    if (reset) begin
      key <= '0;
    end else if (load) begin
`ifdef AES_DEC_KEY_EXPAND_EN
      key <= key_in;
`else
      // Round-10 key arrives on the input; step straight to round key 9.
      key <= inv_key_step(key_in, rcon(4'd10));
`endif
    end else if (step) begin
      key <= inv_key_step(key, rcon(rnd));
`ifdef AES_DEC_KEY_EXPAND_EN
    end else if (fwd_step) begin
      key <= fwd_key_step(key, rcon(rnd));
`endif
    end
  end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher, one round per cycle, round keys derived on the fly.
// AES_DEC_KEY_EXPAND_EN: i_key is the cipher key and a 10-cycle KEYEXP phase precedes the rounds.
//
// state  | meaning
// IDLE   | ready for a block (i_ready high)
// KEYEXP | forward schedule to round-10 key (rnd 1..10), then AddRoundKey at rnd 11
// ROUND  | rnd 9..1 full inverse round, rnd 0 final round and output
module aes_decrypt_core
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] i_block,
  input  logic [127:0] i_key,
  input  logic         i_valid,
  output logic         i_ready,
  output logic [127:0] o_block,
  output logic         o_valid
);

  if (NR != aes_pkg::NR) begin : g_nr_check
    $error("aes_decrypt_core supports only NR=10 (AES-128)");
  end

  state_t       state;
  logic [3:0]   rnd;
  logic [127:0] blk;
  logic [127:0] key;
  logic         ks_load, ks_step;
  logic [3:0]   ks_rnd;

  assign i_ready = (state == IDLE);
  assign ks_load = i_ready && i_valid;

`ifdef AES_DEC_KEY_EXPAND_EN
  logic ks_fwd, kx_done;
  assign kx_done = (state == KEYEXP) && (rnd == 4'd11);
  assign ks_fwd  = (state == KEYEXP) && !kx_done;
  assign ks_step = ((state == ROUND) && (rnd != 4'd0)) || kx_done;
  assign ks_rnd  = kx_done ? 4'd10 : rnd;
`else
  assign ks_step = (state == ROUND) && (rnd != 4'd0);
  assign ks_rnd  = rnd;
`endif

  aes_dec_key_sched u_key_sched (
    .clk      (clk),
    .reset    (reset),
    .load     (ks_load),
    .step     (ks_step),
`ifdef AES_DEC_KEY_EXPAND_EN
    .fwd_step (ks_fwd),
`endif
    .rnd      (ks_rnd),
    .key_in   (i_key),
    .key      (key)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rnd     <= '0;
      blk     <= '0;
      o_block <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
`ifdef AES_DEC_KEY_EXPAND_EN
            blk   <= i_block;
            rnd   <= 4'd1;
            state <= KEYEXP;
`else
            blk   <= i_block ^ i_key;
            rnd   <= 4'd9;
            state <= ROUND;
`endif
          end
        end
`ifdef AES_DEC_KEY_EXPAND_EN
        KEYEXP: begin
          if (rnd == 4'd11) begin
            blk   <= blk ^ key;
            rnd   <= 4'd9;
            state <= ROUND;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
`endif
        ROUND: begin
          if (rnd == 4'd0) begin
            o_block <= inv_sub_bytes(inv_shift_rows(blk)) ^ key;
            o_valid <= 1'b1;
            state   <= IDLE;
          end else begin
            blk <= inv_mix_columns(inv_sub_bytes(inv_shift_rows(blk)) ^ key);
            rnd <= rnd - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Scoreboard bench for aes_decrypt_core: expected plaintext from a forward-cipher model.
// Build with AES_DEC_KEY_EXPAND_EN to exercise the cipher-key input mode.
module tb_aes_decrypt_core;

`ifdef AES_DEC_KEY_EXPAND_EN
  localparam int LAT = 21;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
`else
  localparam int LAT = 10;
  localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`endif
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] i_block = '0;
  logic [127:0] i_key = '0;
  logic         i_valid = 1'b0;
  logic         i_ready;
  logic [127:0] o_block;
  logic         o_valid;

  aes_decrypt_core #(.NR(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_block (i_block),
    .i_key   (i_key),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o_block (o_block),
    .o_valid (o_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] pt;
    int           acc;
  } exp_t;
  exp_t sbq[$];

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every o_valid pulse must match the oldest outstanding block.
  always @(negedge clk) begin
    if (!reset && o_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_o_valid actual=%h required=no_output", o_block);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check128("o_block", o_block, e.pt);
        check_int("latency", cyc - e.acc, LAT);
      end
    end
  end

  // ---------------- reference model: forward AES-128 encryption ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 0; x = a; y = b;
    while (y != 0) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, c, s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  task automatic model_encrypt(input logic [127:0] k, input logic [127:0] p,
                               output logic [127:0] c, output logic [127:0] rk10);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [7:0]  st [16];
    logic [7:0]  tmp [16];
    logic [7:0]  a0, a1, a2, a3;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int b = 0; b < 16; b++) st[b] = p[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) st[b] = sb[st[b]];
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++) tmp[row+4*col] = st[row+4*((col+row)%4)];
      for (int b = 0; b < 16; b++) st[b] = tmp[b];
      if (r < 10) begin
        for (int col = 0; col < 4; col++) begin
          a0 = tmp[4*col]; a1 = tmp[4*col+1]; a2 = tmp[4*col+2]; a3 = tmp[4*col+3];
          st[4*col]   = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
          st[4*col+1] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
          st[4*col+2] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
          st[4*col+3] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int b = 0; b < 16; b++) st[b] = st[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) c[127-8*b -: 8] = st[b];
    rk10 = {w[40], w[41], w[42], w[43]};
  endtask

  // ---------------- stimulus ----------------
  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called at a negedge with the core idle; returns at the negedge after the accept edge.
  task automatic issue(input logic [127:0] b, input logic [127:0] k, input logic [127:0] pt);
    exp_t e;
    check_int("i_ready_idle", int'(i_ready), 1);
    i_block = b;
    i_key = k;
    i_valid = 1'b1;
    e.pt = pt;
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    i_valid = 1'b0;
    i_block = rand128();
    i_key = rand128();
  endtask

  // Busy window after an accept; optional garbage i_valid pulses that must be ignored.
  task automatic busy(input bit garbage);
    for (int j = 0; j < LAT; j++) begin
      check_int("i_ready_busy", int'(i_ready), 0);
      if (garbage && (j == 3 || j == 7)) begin
        i_valid = 1'b1;
        i_block = rand128();
        i_key = rand128();
      end else begin
        i_valid = 1'b0;
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] k, p, c, rk10, kd;
    int acc1, acc2, n;
    exp_t e;
    build_sbox();

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_int("reset_o_valid", int'(o_valid), 0);
    check128("reset_o_block", o_block, '0);
    check_int("reset_i_ready", int'(i_ready), 1);

    issue(C1_CT, C1_KEY, C1_PT);
    busy(1'b0);
    issue(B_CT, B_KEY, B_PT);
    busy(1'b0);

    // Back-to-back with i_valid held high
    check_int("b2b_ready", int'(i_ready), 1);
    i_block = C1_CT; i_key = C1_KEY; i_valid = 1'b1;
    acc1 = cyc + 1;
    e.pt = C1_PT; e.acc = acc1; sbq.push_back(e);
    @(negedge clk);
    i_block = B_CT; i_key = B_KEY;
    n = 0;
    while (!i_ready && n < LAT + 5) begin
      @(negedge clk);
      n++;
    end
    if (!i_ready) begin
      check_int("b2b_ready_timeout", 0, 1);
      i_valid = 1'b0;
    end else begin
      acc2 = cyc + 1;
      e.pt = B_PT; e.acc = acc2; sbq.push_back(e);
      check_int("b2b_spacing", acc2 - acc1, LAT + 1);
      @(negedge clk);
      i_valid = 1'b0;
      busy(1'b0);
    end

    // Busy inputs ignored
    issue(C1_CT, C1_KEY, C1_PT);
    busy(1'b1);

    // Reset mid-operation
    issue(C1_CT, C1_KEY, C1_PT);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;
    check_int("midreset_o_valid", int'(o_valid), 0);
    check128("midreset_o_block", o_block, '0);
    check_int("midreset_i_ready", int'(i_ready), 1);
    issue(C1_CT, C1_KEY, C1_PT);
    busy(1'b0);

    // Randomized blocks against the forward-cipher model
    repeat (24) begin
      k = rand128();
      p = rand128();
      model_encrypt(k, p, c, rk10);
`ifdef AES_DEC_KEY_EXPAND_EN
      kd = k;
`else
      kd = rk10;
`endif
      issue(c, kd, p);
      busy(1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check_int("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
